ni_input_unit_q: RTL and testbench



---
 rtl/ni_input_unit_q_pkg.sv | 26 ++
 rtl/ni_input_unit_q_if.sv | 28 ++
 rtl/ni_input_unit_q_act_fifo.sv | 52 +++++
 rtl/ni_input_unit_q.sv | 150 +++++++++++++++
 tb/tb_ni_input_unit_q.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ni_input_unit_q_pkg.sv
// Shared router info codes, default field widths and decode constants for the
// next-generation NI input unit.
package ni_input_unit_q_pkg;

  localparam int DEF_INFO_W        = 4;
  localparam int DEF_ADDR_W        = 16;
  localparam int DEF_DATA_W        = 16;
  localparam int DEF_PE_ADDR_W     = 6;
  localparam int DEF_ACT_NO_W      = 6;
  localparam int DEF_ACT_REG_W     = 24;
  localparam int DEF_STATUS_ADDR_W = 4;
  localparam int DEF_Q_DEPTH       = 8;

  // addr bit that steers a CONFIG flit to the activation register file
  localparam int STATUS_SEL_BIT = 7;

  typedef enum logic [3:0] {
    ROUTER_INFO_CONFIG        = 4'd0,
    ROUTER_INFO_CALC          = 4'd1,
    ROUTER_INFO_BROADCAST     = 4'd2,
    ROUTER_INFO_FIN_BROADCAST = 4'd3,
    ROUTER_INFO_FIN_COMP      = 4'd4,
    ROUTER_INFO_UV            = 4'd5
  } router_info_e;

endpackage

// File: rtl/ni_input_unit_q_if.sv
// Flit input and activation-queue pop handshake between router side and PE side.
interface ni_input_unit_q_if #(
  parameter int INFO_W    = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int PE_ADDR_W = 6
);

  localparam int FLIT_W = INFO_W + ADDR_W + DATA_W;

  logic                        in_valid;
  logic [FLIT_W-1:0]           in_flit;
  logic                        act_valid;
  logic                        act_ready;
  logic [PE_ADDR_W+DATA_W-1:0] act_data;
  logic                        act_last;

  modport master (
    output in_valid, in_flit, act_ready,
    input  act_valid, act_data, act_last
  );

  modport slave (
    input  in_valid, in_flit, act_ready,
    output act_valid, act_data, act_last
  );

endinterface

// File: rtl/ni_input_unit_q_act_fifo.sv
// ni_act_fifo: first-word-fall-through FIFO with occupancy, full and empty flags.
// A write while full is only taken when a read happens in the same cycle.
module ni_act_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_input_unit_q.sv
// NI input unit: decodes router flits into PE strobes, queues activations and
// returns upstream credits. Optional perf counters under NI_PERF_CNT_EN.
module ni_input_unit_q
  import ni_input_unit_q_pkg::*;
#(
  parameter int INFO_W        = DEF_INFO_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int PE_ADDR_W     = DEF_PE_ADDR_W,
  parameter int ACT_NO_W      = DEF_ACT_NO_W,
  parameter int ACT_REG_W     = DEF_ACT_REG_W,
  parameter int STATUS_ADDR_W = DEF_STATUS_ADDR_W,
  parameter int Q_DEPTH       = DEF_Q_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 pe_idx,
  ni_input_unit_q_if.slave           bus,
  input  logic [ACT_NO_W-1:0]        out_act_no,
  output logic                       pe_status_we,
  output logic [STATUS_ADDR_W-1:0]   pe_status_addr,
  output logic [DATA_W-1:0]          pe_status_data,
  output logic                       in_act_we,
  output logic [ACT_NO_W-1:0]        in_act_addr,
  output logic [ACT_REG_W-1:0]       in_act_data,
  output logic                       pe_start_calc,
  output logic                       comp_done,
  output logic [$clog2(Q_DEPTH):0]   q_count,
  output logic                       q_overflow,
  output logic                       upstream_credit
`ifdef NI_PERF_CNT_EN
  ,
  output logic [15:0]                bcast_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int FLIT_W  = INFO_W + ADDR_W + DATA_W;
  localparam int ENTRY_W = 1 + PE_ADDR_W + DATA_W;
  localparam int CRED_W  = $clog2(Q_DEPTH + 2) + 1;

  logic [INFO_W-1:0]  info;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data;
  logic               is_config, is_calc, is_bcast, is_fin_bcast, is_fin_comp, is_uv;
  logic               is_known, has_act_no;
  logic               instant_consume, push_req, pop, full, empty, dropped;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [CRED_W-1:0]  credit_cnt, credit_sum;
  logic               unused;

  assign info = bus.in_flit[FLIT_W-1 -: INFO_W];
  assign addr = bus.in_flit[ADDR_W+DATA_W-1 -: ADDR_W];
  assign data = bus.in_flit[DATA_W-1:0];

  assign unused = &{1'b0, pe_idx, addr};

  assign is_config    = (info == INFO_W'(ROUTER_INFO_CONFIG));
  assign is_calc      = (info == INFO_W'(ROUTER_INFO_CALC));
  assign is_bcast     = (info == INFO_W'(ROUTER_INFO_BROADCAST));
  assign is_fin_bcast = (info == INFO_W'(ROUTER_INFO_FIN_BROADCAST));
  assign is_fin_comp  = (info == INFO_W'(ROUTER_INFO_FIN_COMP));
  assign is_uv        = (info == INFO_W'(ROUTER_INFO_UV));
  assign is_known     = is_config | is_calc | is_bcast | is_fin_bcast | is_fin_comp | is_uv;
  assign has_act_no   = (out_act_no != '0);

  always_comb begin
    pe_status_we   = 1'b0;
    pe_status_addr = '0;
    pe_status_data = '0;
    in_act_we      = 1'b0;
    in_act_addr    = '0;
    in_act_data    = '0;
    pe_start_calc  = 1'b0;
    comp_done      = 1'b0;
    if (bus.in_valid && is_config && !addr[STATUS_SEL_BIT]) begin
      pe_status_we   = 1'b1;
      pe_status_addr = addr[STATUS_ADDR_W-1:0];
      pe_status_data = data;
    end
    if (bus.in_valid && is_config && addr[STATUS_SEL_BIT]) begin
      in_act_we   = 1'b1;
      in_act_addr = addr[ACT_NO_W:1];
      in_act_data = ACT_REG_W'($signed(data));
    end
    if (bus.in_valid && is_calc)     pe_start_calc = 1'b1;
    if (bus.in_valid && is_fin_comp) comp_done     = 1'b1;
  end

  // A BROADCAST for a PE that owns no outputs is consumed without queueing
  assign instant_consume = bus.in_valid &&
                           (is_config | is_calc | is_fin_comp | (is_bcast && !has_act_no) | !is_known);
  assign push_req        = bus.in_valid && ((is_bcast && has_act_no) | is_uv | is_fin_bcast);
  assign push_entry      = is_fin_bcast ? {1'b1, {(ENTRY_W-1){1'b0}}}
                                        : {1'b0, addr[PE_ADDR_W-1:0], data};

  ni_act_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (Q_DEPTH)
  ) u_act_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (bus.act_ready),
    .pop_data  (head_entry),
    .count     (q_count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.act_valid = !empty;
  assign bus.act_last  = head_entry[ENTRY_W-1];
  assign bus.act_data  = head_entry[ENTRY_W-2:0];
  assign pop           = bus.act_valid && bus.act_ready;
  assign dropped       = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q_overflow <= 1'b0;
    else if (dropped) q_overflow <= 1'b1;
  end

  // Pending credits absorb a second coincident release and emit it next cycle
  assign credit_sum = credit_cnt + CRED_W'(instant_consume) + CRED_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt      <= '0;
      upstream_credit <= 1'b0;
    end else begin
      upstream_credit <= (credit_sum != '0);
      credit_cnt      <= credit_sum - CRED_W'(credit_sum != '0);
    end
  end

`ifdef NI_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcast_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.in_valid && is_bcast && has_act_no && !dropped && bcast_cnt != 16'hFFFF)
        bcast_cnt <= bcast_cnt + 16'd1;
      if (bus.act_valid && !bus.act_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ni_input_unit_q.sv
// Directed bench for ni_input_unit_q; queued activations are checked by a
// scoreboard monitor that compares every pop against the expected-entry queue.
module tb_ni_input_unit_q;
  import ni_input_unit_q_pkg::*;

  localparam int Q_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pe_idx = 6'd3;
  logic [5:0]  out_act_no;
  logic        pe_status_we;
  logic [3:0]  pe_status_addr;
  logic [15:0] pe_status_data;
  logic        in_act_we;
  logic [5:0]  in_act_addr;
  logic [23:0] in_act_data;
  logic        pe_start_calc;
  logic        comp_done;
  logic [3:0]  q_count;
  logic        q_overflow;
  logic        upstream_credit;
`ifdef NI_PERF_CNT_EN
  logic [15:0] bcast_cnt;
  logic [15:0] stall_cnt;
`endif

  ni_input_unit_q_if bus ();

  ni_input_unit_q #(.Q_DEPTH(Q_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pe_idx          (pe_idx),
    .bus             (bus.slave),
    .out_act_no      (out_act_no),
    .pe_status_we    (pe_status_we),
    .pe_status_addr  (pe_status_addr),
    .pe_status_data  (pe_status_data),
    .in_act_we       (in_act_we),
    .in_act_addr     (in_act_addr),
    .in_act_data     (in_act_data),
    .pe_start_calc   (pe_start_calc),
    .comp_done       (comp_done),
    .q_count         (q_count),
    .q_overflow      (q_overflow),
    .upstream_credit (upstream_credit)
`ifdef NI_PERF_CNT_EN
    ,
    .bcast_cnt       (bcast_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          credit_pulses = 0;
  int          last_pops = 0;
  int          c0;
  int          l0;
  logic [22:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] info, input logic [15:0] addr, input logic [15:0] data,
                               input logic [5:0] act_no, input logic ready);
    @(posedge clk);
    #2;
    bus.in_valid  = 1'b1;
    bus.in_flit   = {info, addr, data};
    out_act_no    = act_no;
    bus.act_ready = ready;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ready);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.in_valid  = 1'b0;
      bus.in_flit   = '0;
      bus.act_ready = ready;
    end
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: mid-cycle, pops are compared and accepted pushes queued
  initial begin
    logic [3:0]  m_info;
    logic        pushing;
    logic        popping;
    logic [22:0] exp_e;
    int          model_cnt;
    model_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_cnt = 0;
      end else begin
        if (upstream_credit) credit_pulses++;
        m_info  = bus.in_flit[35:32];
        pushing = bus.in_valid && ((m_info == 4'(ROUTER_INFO_BROADCAST) && out_act_no != 6'd0) ||
                                   m_info == 4'(ROUTER_INFO_UV) || m_info == 4'(ROUTER_INFO_FIN_BROADCAST));
        popping = (model_cnt > 0) && bus.act_ready;
        if (bus.act_valid && bus.act_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_pop: got entry 0x%0h, expected no entry", {bus.act_last, bus.act_data});
          end else begin
            exp_e = exp_q.pop_front();
            checkOutput("pop_entry", 32'({bus.act_last, bus.act_data}), 32'(exp_e));
            if (bus.act_last) last_pops++;
          end
        end
        if (popping) model_cnt--;
        if (pushing && (model_cnt < Q_DEPTH)) begin
          if (m_info == 4'(ROUTER_INFO_FIN_BROADCAST)) exp_e = {1'b1, 22'd0};
          else                                         exp_e = {1'b0, bus.in_flit[21:16], bus.in_flit[15:0]};
          exp_q.push_back(exp_e);
          model_cnt++;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_flit   = '0;
    bus.act_ready = 1'b0;
    out_act_no    = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1, 1'b0);

    checkOutput("reset_act_valid", 32'(bus.act_valid), 32'd0);
    checkOutput("reset_act_data", 32'({bus.act_last, bus.act_data}), 32'd0);
    checkOutput("reset_q_count", 32'(q_count), 32'd0);
    checkOutput("reset_overflow", 32'(q_overflow), 32'd0);
    checkOutput("reset_credit", 32'(upstream_credit), 32'd0);
    checkOutput("reset_strobes", 32'({pe_status_we, in_act_we, pe_start_calc, comp_done}), 32'd0);

    applyStimulus(4'(ROUTER_INFO_CONFIG), 16'h0003, 16'h00AA, 6'd4, 1'b0);
    checkOutput("status_we", 32'(pe_status_we), 32'd1);
    checkOutput("status_addr", 32'(pe_status_addr), 32'd3);
    checkOutput("status_data", 32'(pe_status_data), 32'h00AA);
    checkOutput("status_no_act_we", 32'({in_act_we, in_act_addr}), 32'd0);
    idle(1, 1'b0);
    checkOutput("status_credit", 32'(upstream_credit), 32'd1);
    idle(1, 1'b0);
    checkOutput("status_credit_done", 32'(upstream_credit), 32'd0);

    applyStimulus(4'(ROUTER_INFO_CONFIG), 16'h0085, 16'h8001, 6'd4, 1'b0);
    checkOutput("act_we", 32'(in_act_we), 32'd1);
    checkOutput("act_addr", 32'(in_act_addr), 32'd2);
    checkOutput("act_data_sext", 32'(in_act_data), 32'h00FF8001);
    checkOutput("act_no_status", 32'({pe_status_we, pe_status_data}), 32'd0);
    idle(2, 1'b0);

    c0 = credit_pulses;
    applyStimulus(4'(ROUTER_INFO_CALC), 16'h0000, 16'h0000, 6'd4, 1'b0);
    checkOutput("calc_strobe", 32'({pe_start_calc, comp_done}), 32'b10);
    applyStimulus(4'(ROUTER_INFO_FIN_COMP), 16'h0000, 16'h0000, 6'd4, 1'b0);
    checkOutput("fin_comp_strobe", 32'({pe_start_calc, comp_done}), 32'b01);
    applyStimulus(4'hF, 16'h0085, 16'h1234, 6'd4, 1'b0);
    checkOutput("unknown_no_strobe", 32'({pe_status_we, in_act_we, pe_start_calc, comp_done}), 32'd0);
    idle(3, 1'b0);
    checkOutput("instant_credits", 32'(credit_pulses - c0), 32'd3);
    checkOutput("instant_no_queue", 32'(q_count), 32'd0);

    c0 = credit_pulses;
    l0 = last_pops;
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h0011, 16'h1111, 6'd4, 1'b0);
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h0012, 16'h2222, 6'd4, 1'b0);
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h0013, 16'h3333, 6'd4, 1'b0);
    idle(1, 1'b0);
    checkOutput("bcast_q_count", 32'(q_count), 32'd3);
    checkOutput("bcast_act_valid", 32'(bus.act_valid), 32'd1);
    applyStimulus(4'(ROUTER_INFO_FIN_BROADCAST), 16'h00FF, 16'hFFFF, 6'd4, 1'b0);
    idle(1, 1'b0);
    checkOutput("finb_q_count", 32'(q_count), 32'd4);
    checkOutput("queued_no_credit", 32'(credit_pulses - c0), 32'd0);
    idle(6, 1'b1);
    idle(1, 1'b0);
    checkOutput("drain_q_count", 32'(q_count), 32'd0);
    checkOutput("drain_credits", 32'(credit_pulses - c0), 32'd4);
    checkOutput("drain_last_pops", 32'(last_pops - l0), 32'd1);

    applyStimulus(4'(ROUTER_INFO_UV), 16'h0021, 16'h5555, 6'd0, 1'b0);
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h0022, 16'h6666, 6'd0, 1'b1);
    checkOutput("coinc_pre_credit", 32'(upstream_credit), 32'd0);
    idle(1, 1'b0);
    checkOutput("coinc_credit_1", 32'(upstream_credit), 32'd1);
    idle(1, 1'b0);
    checkOutput("coinc_credit_2", 32'(upstream_credit), 32'd1);
    idle(1, 1'b0);
    checkOutput("coinc_credit_3", 32'(upstream_credit), 32'd0);
    checkOutput("coinc_q_count", 32'(q_count), 32'd0);

    c0 = credit_pulses;
    for (int i = 0; i < Q_DEPTH; i++)
      applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'(i), 16'(16'h0100 + i), 6'd4, 1'b0);
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h003F, 16'hDEAD, 6'd4, 1'b0);
    idle(1, 1'b0);
    checkOutput("full_q_count", 32'(q_count), 32'd8);
    checkOutput("full_overflow", 32'(q_overflow), 32'd1);
    checkOutput("drop_no_credit", 32'(credit_pulses - c0), 32'd0);
    applyStimulus(4'(ROUTER_INFO_BROADCAST), 16'h002A, 16'hBEEF, 6'd4, 1'b1);
    idle(1, 1'b0);
    checkOutput("full_pushpop_count", 32'(q_count), 32'd8);
    checkOutput("full_pushpop_credit", 32'(upstream_credit), 32'd1);
    checkOutput("full_overflow_sticky", 32'(q_overflow), 32'd1);

    idle(1, 1'b1);
    applyStimulus(4'(ROUTER_INFO_CALC), 16'h0000, 16'h0000, 6'd4, 1'b1);
    applyStimulus(4'(ROUTER_INFO_FIN_COMP), 16'h0000, 16'h0000, 6'd4, 1'b1);
    @(posedge clk);
    #2;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.act_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_act_valid", 32'(bus.act_valid), 32'd0);
    checkOutput("rst_q_count", 32'(q_count), 32'd0);
    checkOutput("rst_overflow", 32'(q_overflow), 32'd0);
    checkOutput("rst_credit", 32'(upstream_credit), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    c0  = credit_pulses;
    idle(4, 1'b0);
    checkOutput("rst_no_pending_credit", 32'(credit_pulses - c0), 32'd0);
    checkOutput("rst_still_empty", 32'({bus.act_valid, q_count}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
